// File: rtl/jpegls_pipe_ctrl_if.sv
// Pixel source handshake for the JPEG-LS pipeline controller:
// the source offers a pixel (with end-of-frame mark) and the controller accepts it.
interface jpegls_pipe_ctrl_if;
  logic pixel_valid;
  logic pixel_ready;
  logic eof_in;

  modport master (output pixel_valid, output eof_in, input pixel_ready);
  modport slave  (input pixel_valid, input eof_in, output pixel_ready);
endinterface

// File: rtl/jpegls_pipe_ctrl.sv
// Flow controller for the JPEG-LS encoder pipeline: per-stage token tracking,
// register enables, global stall on bit-packer back-pressure and end-of-frame flush.
module jpegls_pipe_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int CNT_W      = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  jpegls_pipe_ctrl_if.slave     pix,
  input  logic                  packer_stall,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  out_strobe,
  output logic                  eof_out,
  output logic                  frame_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      pixel_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] eofb;
  logic                  advance;
  logic                  accept;
  logic                  in_idle;

  assign advance         = !packer_stall;
  assign in_idle         = (state == IDLE);
  assign pix.pixel_ready = advance & (in_idle | (state == RUN));
  assign accept          = pix.pixel_valid & pix.pixel_ready;

  // Stage k loads when a token moves into it; stage 0 loads on a source transfer.
  assign stage_en    = {valid[NUM_STAGES-2:0] & {(NUM_STAGES-1){advance}}, accept};
  assign stage_valid = valid;
  assign out_strobe  = advance & valid[NUM_STAGES-1];
  assign eof_out     = out_strobe & eofb[NUM_STAGES-1];
  assign frame_done  = (state == DONE);
  assign busy        = !in_idle | (|valid);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      eofb  <= '0;
    end else if (advance) begin
      valid <= {valid[NUM_STAGES-2:0], accept};
      eofb  <= {eofb[NUM_STAGES-2:0], accept & pix.eof_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = pix.eof_in ? FLUSH : RUN;
      RUN:     if (accept && pix.eof_in) state_nxt = FLUSH;
      FLUSH:   if (eof_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first accept of a frame restarts the count; the count otherwise holds
  // through DONE/IDLE so software can read the finished frame's total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
    end else if (accept && in_idle) begin
      pixel_count <= '0;
    end else if (out_strobe && (pixel_count != CNT_MAX)) begin
      pixel_count <= pixel_count + CNT_W'(1);
    end
  end

endmodule
